// File: rtl/lcd_byte_sequencer_pkg.sv
// Shared types and HD44780 constants for the LCD byte sequencer.
// LCD_SEQ_INIT_CLEAR_EN adds the clear-display command to the init command list.
package lcd_byte_sequencer_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT = 4'd0,
        INIT_NIB = 4'd1,
        INIT_GAP = 4'd2,
        INIT_CMD = 4'd3,
        IDLE     = 4'd4,
        SEND_HI  = 4'd5,
        ACK_HI   = 4'd6,
        RDY_HI   = 4'd7,
        SEND_LO  = 4'd8,
        ACK_LO   = 4'd9,
        RDY_LO   = 4'd10
    } lcd_seq_state_t;

    localparam logic [7:0] LCD_CMD_FUNC_SET_4BIT = 8'h28;
    localparam logic [7:0] LCD_CMD_DISP_ON       = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR         = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE    = 8'h06;

    localparam logic [3:0] LCD_INIT_NIBBLE_8BIT  = 4'h3;
    localparam logic [3:0] LCD_INIT_NIBBLE_4BIT  = 4'h2;
    localparam logic [1:0] LCD_INIT_NIB_LAST     = 2'd3;

`ifdef LCD_SEQ_INIT_CLEAR_EN
    localparam logic [1:0] LCD_INIT_CMD_LAST     = 2'd3;
`else
    localparam logic [1:0] LCD_INIT_CMD_LAST     = 2'd2;
`endif

    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_CMD_FUNC_SET_4BIT;
            2'd1:    cmd = LCD_CMD_DISP_ON;
`ifdef LCD_SEQ_INIT_CLEAR_EN
            2'd2:    cmd = LCD_CMD_CLEAR;
`endif
            default: cmd = LCD_CMD_ENTRY_MODE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_sequencer_nibble_issuer.sv
// One-nibble send/acknowledge/ready handshake towards lcd_interface.
// Shared by the init-nibble, init-command and user-byte paths of lcd_byte_sequencer.
module lcd_nibble_issuer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_nibble,
    input  logic       i_rs,
    input  logic       i_is_ready,
    output logic       o_sent,
    output logic       o_acked,
    output logic       o_done,
    output logic [3:0] o_display_data,
    output logic       o_display_data_valid,
    output logic       o_RS
);
    localparam logic [1:0] ISS_IDLE = 2'd0;
    localparam logic [1:0] ISS_ACK  = 2'd1;
    localparam logic [1:0] ISS_RDY  = 2'd2;

    logic [1:0] phase_q, phase_d;
    logic       ack_wait_q, ack_wait_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       rs_q, rs_d;

    // Handshake phase sequencing; an interface that never drops ready is taken as accepted after 2 cycles.
    always_comb begin
        phase_d    = phase_q;
        ack_wait_d = ack_wait_q;
        data_d     = data_q;
        rs_d       = rs_q;
        valid_d    = 1'b0;
        o_sent     = 1'b0;
        o_acked    = 1'b0;
        o_done     = 1'b0;
        case (phase_q)
            ISS_IDLE: begin
                if (i_start && i_is_ready) begin
                    o_sent     = 1'b1;
                    valid_d    = 1'b1;
                    data_d     = i_nibble;
                    rs_d       = i_rs;
                    ack_wait_d = 1'b0;
                    phase_d    = ISS_ACK;
                end else begin
                    phase_d    = ISS_IDLE;
                end
            end
            ISS_ACK: begin
                if (!i_is_ready || ack_wait_q) begin
                    o_acked    = 1'b1;
                    ack_wait_d = 1'b0;
                    phase_d    = ISS_RDY;
                end else begin
                    ack_wait_d = 1'b1;
                end
            end
            ISS_RDY: begin
                if (i_is_ready) begin
                    o_done  = 1'b1;
                    phase_d = ISS_IDLE;
                end else begin
                    phase_d = ISS_RDY;
                end
            end
            default: phase_d = ISS_IDLE;
        endcase
    end

    // Handshake state and registered nibble outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q    <= ISS_IDLE;
            ack_wait_q <= 1'b0;
            data_q     <= 4'h0;
            valid_q    <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            ack_wait_q <= ack_wait_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            rs_q       <= rs_d;
        end
    end

    assign o_display_data       = data_q;
    assign o_display_data_valid = valid_q;
    assign o_RS                 = rs_q;

endmodule

// File: rtl/lcd_byte_sequencer.sv
// HD44780 power-up / 4-bit init sequencer and byte-to-nibble feeder for lcd_interface.
// Define LCD_SEQ_INIT_CLEAR_EN to include the clear-display command (and its wait) in init.
module lcd_byte_sequencer
    import lcd_byte_sequencer_pkg::*;
#(
    parameter int POWERUP_CYCLES  = 1_080_000,
    parameter int INIT_GAP_CYCLES = 111_000,
    parameter int CLEAR_CYCLES    = 44_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_rs,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic       o_init_done,
    output logic [3:0] o_display_data,
    output logic       o_display_data_valid,
    output logic       o_RS,
    input  logic       i_is_ready
);
    localparam int MAX_PG     = (POWERUP_CYCLES > INIT_GAP_CYCLES) ? POWERUP_CYCLES : INIT_GAP_CYCLES;
    localparam int MAX_CYCLES = (MAX_PG > CLEAR_CYCLES) ? MAX_PG : CLEAR_CYCLES;
    localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INIT_GAP_CYCLES);
`ifdef LCD_SEQ_INIT_CLEAR_EN
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES);
`endif

    lcd_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwr_armed_q, pwr_armed_d;
    logic [1:0]       nib_idx_q, nib_idx_d;
    logic [1:0]       cmd_idx_q, cmd_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             byte_ready_q, byte_ready_d;
    logic             init_done_q, init_done_d;

    logic             iss_start;
    logic [3:0]       iss_nibble;
    logic             iss_rs;
    logic             iss_sent, iss_acked, iss_done;

    lcd_nibble_issuer u_issuer (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_start              (iss_start),
        .i_nibble             (iss_nibble),
        .i_rs                 (iss_rs),
        .i_is_ready           (i_is_ready),
        .o_sent               (iss_sent),
        .o_acked              (iss_acked),
        .o_done               (iss_done),
        .o_display_data       (o_display_data),
        .o_display_data_valid (o_display_data_valid),
        .o_RS                 (o_RS)
    );

    // Sequencer next-state: init nibbles and commands share the byte path with user traffic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pwr_armed_d  = pwr_armed_q;
        nib_idx_d    = nib_idx_q;
        cmd_idx_d    = cmd_idx_q;
        byte_d       = byte_q;
        rs_d         = rs_q;
        byte_ready_d = byte_ready_q;
        init_done_d  = init_done_q;
        iss_start    = 1'b0;
        iss_nibble   = byte_q[7:4];
        iss_rs       = rs_q;
        case (state_q)
            PWR_WAIT: begin
                // Counter resets to 0, so the power-up delay is loaded on the first cycle here.
                if (!pwr_armed_q) begin
                    pwr_armed_d = 1'b1;
                    if (POWERUP_CYCLES == 0) begin
                        state_d = INIT_NIB;
                    end else begin
                        cnt_d = PWR_LOAD;
                    end
                end else if (cnt_q == '0) begin
                    state_d = INIT_NIB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INIT_NIB: begin
                iss_start  = 1'b1;
                iss_rs     = 1'b0;
                iss_nibble = (nib_idx_q == LCD_INIT_NIB_LAST) ? LCD_INIT_NIBBLE_4BIT : LCD_INIT_NIBBLE_8BIT;
                if (!iss_done) begin
                    state_d = INIT_NIB;
                end else if (nib_idx_q == LCD_INIT_NIB_LAST) begin
                    state_d = INIT_CMD;
                end else begin
                    nib_idx_d = nib_idx_q + 2'd1;
                    cnt_d     = GAP_LOAD;
                    state_d   = INIT_GAP;
                end
            end
            INIT_GAP: begin
                if (cnt_q == '0) begin
                    state_d = (cmd_idx_q != 2'd0) ? INIT_CMD : INIT_NIB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INIT_CMD: begin
                byte_d  = lcd_init_cmd(cmd_idx_q);
                rs_d    = 1'b0;
                state_d = SEND_HI;
            end
            IDLE: begin
                if (i_byte_valid && byte_ready_q) begin
                    byte_d       = i_byte;
                    rs_d         = i_byte_rs;
                    byte_ready_d = 1'b0;
                    state_d      = SEND_HI;
                end else begin
                    state_d      = IDLE;
                end
            end
            SEND_HI: begin
                iss_start = 1'b1;
                state_d   = iss_sent ? ACK_HI : SEND_HI;
            end
            ACK_HI:  state_d = iss_acked ? RDY_HI : ACK_HI;
            RDY_HI:  state_d = iss_done ? SEND_LO : RDY_HI;
            SEND_LO: begin
                iss_start  = 1'b1;
                iss_nibble = byte_q[3:0];
                state_d    = iss_sent ? ACK_LO : SEND_LO;
            end
            ACK_LO:  state_d = iss_acked ? RDY_LO : ACK_LO;
            RDY_LO: begin
                if (!iss_done) begin
                    state_d = RDY_LO;
                end else if (init_done_q || (cmd_idx_q == LCD_INIT_CMD_LAST)) begin
                    init_done_d  = 1'b1;
                    byte_ready_d = 1'b1;
                    state_d      = IDLE;
`ifdef LCD_SEQ_INIT_CLEAR_EN
                end else if (byte_q == LCD_CMD_CLEAR) begin
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    cnt_d     = CLR_LOAD;
                    state_d   = INIT_GAP;
`endif
                end else begin
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    state_d   = INIT_CMD;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // Sequencer state, delay counter and byte latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            pwr_armed_q  <= 1'b0;
            nib_idx_q    <= 2'd0;
            cmd_idx_q    <= 2'd0;
            byte_q       <= 8'h00;
            rs_q         <= 1'b0;
            byte_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwr_armed_q  <= pwr_armed_d;
            nib_idx_q    <= nib_idx_d;
            cmd_idx_q    <= cmd_idx_d;
            byte_q       <= byte_d;
            rs_q         <= rs_d;
            byte_ready_q <= byte_ready_d;
            init_done_q  <= init_done_d;
        end
    end

    assign o_byte_ready = byte_ready_q;
    assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Self-checking bench for lcd_byte_sequencer: scoreboard of expected nibble strobes
// against a behavioural lcd_interface; honours LCD_SEQ_INIT_CLEAR_EN like the design.
module tb_lcd_byte_sequencer;

    localparam int P_PWR = 20;
    localparam int P_GAP = 5;
    localparam int P_CLR = 8;

    localparam logic [3:0] INIT_NIBS [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
`ifdef LCD_SEQ_INIT_CLEAR_EN
    localparam int NCMD = 4;
    localparam logic [7:0] CMDS [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};
`else
    localparam int NCMD = 3;
    localparam logic [7:0] CMDS [3] = '{8'h28, 8'h0C, 8'h06};
`endif
    localparam int INIT_LEN = 4 + 2 * NCMD;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_byte;
    logic       i_byte_rs;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_init_done;
    logic [3:0] o_display_data;
    logic       o_display_data_valid;
    logic       o_RS;
    logic       i_is_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [4:0] exp_q [$];
    int         strobe_t [$];
    int         n_accept = 0;
    int         acc_cyc = 0;
    int         hi_cyc = 0;
    int         rel_cyc = 0;
    bit         early_rdy = 1'b0;
    bit         busy_rdy = 1'b0;
    bit         dbl_strobe = 1'b0;
    bit         prev_valid = 1'b0;
    bit         always_ready = 1'b0;
    int         busy = 0;

    lcd_byte_sequencer #(
        .POWERUP_CYCLES  (P_PWR),
        .INIT_GAP_CYCLES (P_GAP),
        .CLEAR_CYCLES    (P_CLR)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_byte               (i_byte),
        .i_byte_rs            (i_byte_rs),
        .i_byte_valid         (i_byte_valid),
        .o_byte_ready         (o_byte_ready),
        .o_init_done          (o_init_done),
        .o_display_data       (o_display_data),
        .o_display_data_valid (o_display_data_valid),
        .o_RS                 (o_RS),
        .i_is_ready           (i_is_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Cycle counter for latency and gap measurements.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural lcd_interface: busy for 4 cycles starting the cycle after a strobe.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy <= 0;
        else if (o_display_data_valid && !always_ready) busy <= 4;
        else if (busy != 0) busy <= busy - 1;
    end
    assign i_is_ready = (busy == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_init();
        exp_q.delete();
        strobe_t.delete();
        foreach (INIT_NIBS[i]) exp_q.push_back({1'b0, INIT_NIBS[i]});
        foreach (CMDS[i]) begin
            exp_q.push_back({1'b0, CMDS[i][7:4]});
            exp_q.push_back({1'b0, CMDS[i][3:0]});
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_byte_ready && !o_init_done) early_rdy = 1'b1;
                if (o_byte_ready && exp_q.size() != 0) busy_rdy = 1'b1;
                if (o_display_data_valid) begin
                    if (prev_valid) dbl_strobe = 1'b1;
                    strobe_t.push_back(cyc);
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL strobe_extra observed=%0h expected=none", {o_RS, o_display_data});
                    end
                    if (exp_q.size() != 0) begin
                        if (exp_q.size() == 2) hi_cyc = cyc;
                        e = exp_q.pop_front();
                        chk("strobe", 32'({o_RS, o_display_data}), 32'(e));
                    end
                end
                prev_valid = o_display_data_valid;
                if (i_byte_valid && o_byte_ready) begin
                    exp_q.push_back({i_byte_rs, i_byte[7:4]});
                    exp_q.push_back({i_byte_rs, i_byte[3:0]});
                    n_accept++;
                    acc_cyc = cyc;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic rs, input bit keep);
        int k = 0;
        @(posedge i_clk); #1;
        i_byte = b; i_byte_rs = rs; i_byte_valid = 1'b1;
        @(negedge i_clk);
        while (!o_byte_ready && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("accept_timeout", 32'(o_byte_ready), 32'd1);
        @(posedge i_clk); #1;
        if (!keep) i_byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(exp_q.size() == 0 && o_byte_ready) && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("idle_timeout", 32'(exp_q.size() == 0 && o_byte_ready), 32'd1);
    endtask

    task automatic wait_init();
        int k = 0;
        while (!o_init_done && k < 3000) begin
            @(negedge i_clk);
            k++;
        end
        chk("init_timeout", 32'(o_init_done), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(o_display_data), 32'd0);
        chk({tag, "_valid"}, 32'(o_display_data_valid), 32'd0);
        chk({tag, "_rs"},    32'(o_RS), 32'd0);
        chk({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
        chk({tag, "_done"},  32'(o_init_done), 32'd0);
    endtask

    initial begin
        int a0;
        int k;
        logic [7:0] rb;
        logic       rr;

        // Reset with a request already pending: it must not leak into init.
        i_rst_n = 1'b0;
        i_byte = 8'hA5; i_byte_rs = 1'b1; i_byte_valid = 1'b1;
        load_init();
        #3;
        chk_outputs_zero("reset");
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        rel_cyc = cyc;

        wait_init();
        chk("strobes_at_init_done", 32'(strobe_t.size()), 32'(INIT_LEN));
        if (strobe_t.size() == INIT_LEN) begin
            for (int i = 0; i < 3; i++)
                chk("gap_after_3", 32'(strobe_t[i+1] - strobe_t[i] > P_GAP), 32'd1);
`ifdef LCD_SEQ_INIT_CLEAR_EN
            chk("gap_after_clear", 32'(strobe_t[10] - strobe_t[9] > P_CLR), 32'd1);
`endif
            chk("powerup_wait", 32'(strobe_t[0] - rel_cyc >= P_PWR), 32'd1);
        end
        chk("ready_before_init", 32'(early_rdy), 32'd0);

        // The held request is taken only once init is complete.
        send(8'hA5, 1'b1, 1'b0);
        wait_idle();

        // Single user data byte.
        a0 = n_accept;
        send(8'h4B, 1'b1, 1'b0);
        wait_idle();
        chk("byte_4B_accepts", 32'(n_accept - a0), 32'd1);
        chk("hi_latency", 32'(hi_cyc - acc_cyc), 32'd2);

        // Back-to-back bytes with valid held high.
        a0 = n_accept;
        send(8'h31, 1'b0, 1'b1);
        send(8'h80, 1'b0, 1'b0);
        wait_idle();
        repeat (5) @(negedge i_clk);
        chk("b2b_accepts", 32'(n_accept - a0), 32'd2);

        // Random bytes, alternating interface behaviour (incl. never-dropping ready).
        for (int n = 0; n < 8; n++) begin
            always_ready = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            rb = 8'($urandom);
            rr = 1'($urandom);
            send(rb, rr, 1'b0);
            wait_idle();
        end
        always_ready = 1'b0;
        chk("ready_while_busy", 32'(busy_rdy), 32'd0);
        chk("double_strobe", 32'(dbl_strobe), 32'd0);

        // Reset between the high and low nibble.
        rb = 8'($urandom);
        send(rb, 1'b1, 1'b0);
        k = 0;
        while (exp_q.size() != 1 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("mid_byte_reached", 32'(exp_q.size()), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        early_rdy = 1'b0;
        load_init();
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        rel_cyc = cyc;
        wait_init();
        chk("reinit_strobes", 32'(strobe_t.size()), 32'(INIT_LEN));
        if (strobe_t.size() != 0)
            chk("reinit_powerup_wait", 32'(strobe_t[0] - rel_cyc >= P_PWR), 32'd1);
        chk("reinit_ready_early", 32'(early_rdy), 32'd0);

        send(8'hC3, 1'b1, 1'b0);
        wait_idle();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
